// File: rtl/vm2_board_ctrl.sv
// vm2_board_ctrl: 1801VM2 board glue - slow clock enable, shadow decode, ROM ack, vectors, timer.
// Optional bus-timeout ack enabled by defining BUS_TIMEOUT_EN.
module vm2_board_ctrl #(
  parameter int unsigned SLOW_DIV = 22,
  parameter logic [3:0]  ROM_PAGE = 4'b1110,
  parameter logic [3:0]  RAM_PAGE = 4'b1111,
  parameter int unsigned ROM_WAIT = 1,
  parameter int unsigned DEB_LEN  = 2,
  parameter logic [15:0] STARTUP  = 16'o140001,
  parameter int unsigned TMO      = 64
) (
  input  logic        clk_p,
  input  logic        dclo,
  input  logic        cpuslow,
  output logic        clk_ena,
  input  logic [16:0] cpu_adr,
  input  logic        cpu_cyc,
  input  logic        cpu_stb,
  input  logic        cpu_gnt,
  output logic        rom_stb,
  output logic        sysram_stb,
  input  logic [15:0] rom_dat_i,
  input  logic [15:0] bus_dat_i,
  output logic [15:0] cpu_dat_i,
  input  logic        global_ack,
  output logic        cpu_ack,
  input  logic        una,
  input  logic [15:0] ivec,
  input  logic        cpu_istb,
  input  logic        iack,
  output logic [15:0] vector,
  output logic        istb,
  output logic        vack,
  input  logic        timer_50,
  input  logic        timer_button,
  output logic        evnt,
  output logic        timer_status,
  output logic        bus_err
);

  logic [7:0] cnt;

  always_ff @(posedge clk_p) begin
    if (dclo)
      cnt <= '0;
    else if (cnt == 8'(SLOW_DIV - 1))
      cnt <= '0;
    else
      cnt <= cnt + 8'd1;
  end

  assign clk_ena = ~cpuslow | (cnt == 8'd0);

  logic rom_sel;
  logic ram_sel;

  assign rom_sel    = cpu_cyc & cpu_stb
                    & (cpu_adr[16:13] == ROM_PAGE);
  assign ram_sel    = cpu_cyc & cpu_stb
                    & (cpu_adr[16:13] == RAM_PAGE);
  assign rom_stb    = rom_sel;
  assign sysram_stb = ram_sel;
  assign cpu_dat_i  = rom_sel ? rom_dat_i : bus_dat_i;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_ACK
  } rom_st_t;

  rom_st_t    rom_st;
  logic [3:0] wcnt;
  logic       rom_ack;
  logic       rom_ack_v;

  // wcnt==1 ends WAIT so the ack lands ROM_WAIT+1 cycles after the strobe
  always_ff @(posedge clk_p) begin
    if (dclo) begin
      rom_st  <= R_IDLE;
      wcnt    <= '0;
      rom_ack <= 1'b0;
    end else begin
      unique case (rom_st)
        R_IDLE: begin
          if (rom_sel) begin
            wcnt <= 4'(ROM_WAIT);
            if (ROM_WAIT == 0) begin
              rom_st  <= R_ACK;
              rom_ack <= 1'b1;
            end else begin
              rom_st <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (!rom_sel) begin
            rom_st <= R_IDLE;
          end else if (wcnt <= 4'd1) begin
            rom_st  <= R_ACK;
            rom_ack <= 1'b1;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        R_ACK: begin
          if (!rom_sel) begin
            rom_st  <= R_IDLE;
            rom_ack <= 1'b0;
          end
        end
        default: begin
          rom_st  <= R_IDLE;
          rom_ack <= 1'b0;
        end
      endcase
    end
  end

  assign rom_ack_v = rom_ack & rom_sel;

  logic tmo_ack;

`ifdef BUS_TIMEOUT_EN
  logic [9:0] tcnt;
  logic       busy;
  logic       tmo_hit;

  assign busy    = cpu_cyc & cpu_stb;
  assign tmo_hit = busy & cpu_gnt & ~global_ack & ~rom_ack_v
                 & (tcnt == 10'(TMO - 1));

  always_ff @(posedge clk_p) begin
    if (dclo || !busy || global_ack || rom_ack_v)
      tcnt <= '0;
    else if (cpu_gnt)
      tcnt <= tmo_hit ? 10'd0 : tcnt + 10'd1;
  end

  assign tmo_ack = tmo_hit;
  assign bus_err = tmo_hit;
`else
  logic [10:0] unused_tmo;

  assign unused_tmo = {cpu_gnt, 10'(TMO)};
  assign tmo_ack    = 1'b0;
  assign bus_err    = 1'b0;
`endif

  logic [12:0] unused_adr;

  assign unused_adr = cpu_adr[12:0];
  assign cpu_ack    = global_ack | rom_ack_v | tmo_ack;

  assign vector = una ? STARTUP : ivec;
  assign istb   = cpu_istb & ~una;
  assign vack   = iack | una;

  logic [2:0]         t_sy;
  logic [1:0]         b_sy;
  logic [DEB_LEN-1:0] deb;
  logic [DEB_LEN-1:0] deb_nx;
  logic               tbevent;
  logic               tick;
  logic               tstat;

  assign tick   = t_sy[1] & ~t_sy[2];
  assign deb_nx = DEB_LEN'({deb, b_sy[1]});

  // tbevent latches a toggle until the button is seen fully released
  always_ff @(posedge clk_p) begin
    if (dclo) begin
      t_sy    <= '0;
      b_sy    <= '0;
      deb     <= '0;
      tbevent <= 1'b0;
      tstat   <= 1'b1;
    end else begin
      t_sy <= {t_sy[1:0], timer_50};
      b_sy <= {b_sy[0], timer_button};
      if (tick) begin
        deb <= deb_nx;
        if ((&deb_nx) && !tbevent) begin
          tstat   <= ~tstat;
          tbevent <= 1'b1;
        end else if (~|deb_nx) begin
          tbevent <= 1'b0;
        end
      end
    end
  end

  assign timer_status = tstat;
  assign evnt         = t_sy[1] & tstat;

endmodule

// File: tb/tb_vm2_board_ctrl.sv
// Bench for vm2_board_ctrl: random bus/vector traffic into scoreboards,
// plus debounce, clock-enable and reset checks against a reference model.
`timescale 1ns/1ps
module tb_vm2_board_ctrl;

  localparam int          SLOW_DIV = 22;
  localparam int          ROM_WAIT = 1;
  localparam int          DEB_LEN  = 2;
  localparam int          TMO      = 64;
  localparam logic [15:0] STARTUP  = 16'o140001;

  logic        clk_p = 0;
  logic        dclo = 1;
  logic        cpuslow = 1;
  logic        clk_ena;
  logic [16:0] cpu_adr = '0;
  logic        cpu_cyc = 0;
  logic        cpu_stb = 0;
  logic        cpu_gnt = 1;
  logic        rom_stb;
  logic        sysram_stb;
  logic [15:0] rom_dat_i = '0;
  logic [15:0] bus_dat_i = '0;
  logic [15:0] cpu_dat_i;
  logic        global_ack = 0;
  logic        cpu_ack;
  logic        una = 0;
  logic [15:0] ivec = '0;
  logic        cpu_istb = 0;
  logic        iack = 0;
  logic [15:0] vector;
  logic        istb;
  logic        vack;
  logic        timer_50 = 0;
  logic        timer_button = 0;
  logic        evnt;
  logic        timer_status;
  logic        bus_err;

  vm2_board_ctrl dut (
    .clk_p(clk_p), .dclo(dclo), .cpuslow(cpuslow),
    .clk_ena(clk_ena), .cpu_adr(cpu_adr),
    .cpu_cyc(cpu_cyc), .cpu_stb(cpu_stb),
    .cpu_gnt(cpu_gnt), .rom_stb(rom_stb),
    .sysram_stb(sysram_stb), .rom_dat_i(rom_dat_i),
    .bus_dat_i(bus_dat_i), .cpu_dat_i(cpu_dat_i),
    .global_ack(global_ack), .cpu_ack(cpu_ack),
    .una(una), .ivec(ivec), .cpu_istb(cpu_istb),
    .iack(iack), .vector(vector), .istb(istb),
    .vack(vack), .timer_50(timer_50),
    .timer_button(timer_button), .evnt(evnt),
    .timer_status(timer_status), .bus_err(bus_err)
  );

  always #5 clk_p = ~clk_p;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] dat;
    int          lat;
    logic        err;
  } bus_exp_t;

  typedef struct {
    logic [15:0] vec;
    logic        istb;
  } vec_exp_t;

  bus_exp_t bq[$];
  vec_exp_t vq[$];

  bit run = 0;
  int since = 0;

  // cycles elapsed since the last reset edge
  always @(posedge clk_p)
    since <= dclo ? 0 : since + 1;

  always @(negedge clk_p) begin
    if (run) begin
      chk("clk_ena", clk_ena,
          32'(!cpuslow || (since % SLOW_DIV == 0)));
      if (bus_err && !cpu_ack)
        chk("bus_err_without_ack", bus_err, 0);
    end
  end

  int idx = 0;
  bit acked = 0;

  always @(negedge clk_p) begin
    bus_exp_t e;
    if (run) begin
      if (cpu_cyc && cpu_stb) begin
        if (cpu_ack && !acked) begin
          acked = 1;
          if (bq.size() == 0) begin
            chk("unexpected_ack", 1, 0);
          end else begin
            e = bq.pop_front();
            chk("ack_latency", idx, e.lat);
            chk("ack_data", cpu_dat_i, e.dat);
            chk("ack_bus_err", bus_err, e.err);
          end
        end
        idx++;
      end else begin
        idx = 0;
        acked = 0;
      end
    end
  end

  always @(negedge clk_p) begin
    vec_exp_t v;
    if (run && vack) begin
      if (vq.size() == 0) begin
        chk("unexpected_vack", 1, 0);
      end else begin
        v = vq.pop_front();
        chk("vector", vector, v.vec);
        chk("istb", istb, v.istb);
      end
    end
  end

  bit model_status;
  bit model_latched;
  int hist[$];

  task automatic model_reset();
    model_status = 1;
    model_latched = 0;
    hist.delete();
    repeat (DEB_LEN) hist.push_back(0);
  endtask

  // status flips once per stable press of DEB_LEN ticks
  task automatic model_tick(bit b);
    int ones = 0;
    hist.push_back(int'(b));
    void'(hist.pop_front());
    foreach (hist[i]) ones += hist[i];
    if (ones == DEB_LEN && !model_latched) begin
      model_status = !model_status;
      model_latched = 1;
    end else if (ones == 0) begin
      model_latched = 0;
    end
  endtask

  task automatic tick(bit btn);
    @(posedge clk_p); #1;
    timer_button = btn;
    repeat (4) @(posedge clk_p);
    #1 timer_50 = 1;
    model_tick(btn);
    repeat (4) @(posedge clk_p);
    @(negedge clk_p);
    chk("timer_status", timer_status, model_status);
    chk("evnt_high", evnt, model_status);
    @(posedge clk_p); #1;
    timer_50 = 0;
    repeat (4) @(posedge clk_p);
    @(negedge clk_p);
    chk("evnt_low", evnt, 0);
  endtask

  task automatic bus_tx(int kind);
    logic [3:0] page;
    int d;
    int h;
    @(posedge clk_p); #1;
    cpuslow = 1'($urandom_range(0, 1));
    case (kind)
      0: page = 4'b1110;
      1: page = 4'b1111;
      default: page = 4'($urandom_range(0, 13));
    endcase
    cpu_adr = {page, 13'($urandom)};
    rom_dat_i = 16'($urandom);
    bus_dat_i = 16'($urandom);
    cpu_cyc = 1;
    cpu_stb = 1;
    d = $urandom_range(1, 4);
    h = ROM_WAIT + 2 + $urandom_range(0, 2);
    if (kind == 0)
      bq.push_back('{rom_dat_i, ROM_WAIT + 1, 1'b0});
    else
      bq.push_back('{bus_dat_i, d, 1'b0});
    @(negedge clk_p);
    chk("rom_stb", rom_stb, 32'(kind == 0));
    chk("sysram_stb", sysram_stb, 32'(kind == 1));
    if (kind == 0) begin
      repeat (h) @(posedge clk_p);
      #1 cpu_stb = 0;
      cpu_cyc = 0;
      @(negedge clk_p);
      chk("ack_after_drop", cpu_ack, 0);
    end else begin
      repeat (d) @(posedge clk_p);
      #1 global_ack = 1;
      @(posedge clk_p); #1;
      global_ack = 0;
      cpu_stb = 0;
      cpu_cyc = 0;
    end
  endtask

  task automatic rom_abort();
    @(posedge clk_p); #1;
    cpu_adr = {4'b1110, 13'($urandom)};
    cpu_cyc = 1;
    cpu_stb = 1;
    @(posedge clk_p); #1;
    cpu_cyc = 0;
    cpu_stb = 0;
    repeat (2) @(negedge clk_p);
    chk("abort_no_ack", cpu_ack, 0);
  endtask

  task automatic vec_tx(bit use_una);
    @(posedge clk_p); #1;
    ivec = 16'($urandom);
    if (use_una) begin
      una = 1;
      cpu_istb = 1'($urandom_range(0, 1));
      vq.push_back('{STARTUP, 1'b0});
    end else begin
      cpu_istb = 1;
      @(negedge clk_p);
      chk("istb_wait", istb, 1);
      chk("vack_wait", vack, 0);
      @(posedge clk_p); #1;
      iack = 1;
      vq.push_back('{ivec, 1'b1});
    end
    @(posedge clk_p); #1;
    una = 0;
    iack = 0;
    cpu_istb = 0;
  endtask

`ifdef BUS_TIMEOUT_EN
  task automatic tmo_tx(int p);
    @(posedge clk_p); #1;
    cpu_adr = {4'b0010, 13'($urandom)};
    bus_dat_i = 16'($urandom);
    cpu_gnt = 1;
    cpu_cyc = 1;
    cpu_stb = 1;
    bq.push_back('{bus_dat_i, TMO - 1 + p, 1'b1});
    repeat (10) @(posedge clk_p);
    #1 cpu_gnt = (p == 0);
    repeat (p) @(posedge clk_p);
    #1 cpu_gnt = 1;
    repeat (TMO - 10) @(posedge clk_p);
    #1 cpu_stb = 0;
    cpu_cyc = 0;
  endtask

  task automatic tmo_race();
    @(posedge clk_p); #1;
    cpu_adr = {4'b0010, 13'($urandom)};
    bus_dat_i = 16'($urandom);
    cpu_cyc = 1;
    cpu_stb = 1;
    bq.push_back('{bus_dat_i, TMO - 1, 1'b0});
    repeat (TMO - 1) @(posedge clk_p);
    #1 global_ack = 1;
    @(posedge clk_p); #1;
    global_ack = 0;
    cpu_stb = 0;
    cpu_cyc = 0;
  endtask
`endif

  initial begin
    int highs;
    bit b;
    model_reset();
    @(posedge clk_p); #1;
    run = 1;
    @(negedge clk_p);
    chk("rst_timer_status", timer_status, 1);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_evnt", evnt, 0);
    chk("rst_clk_ena", clk_ena, 1);
    @(posedge clk_p); #1;
    dclo = 0;

    highs = 0;
    repeat (3 * SLOW_DIV) begin
      @(negedge clk_p);
      highs += int'(clk_ena);
    end
    chk("slow_ena_count", highs, 3);
    @(posedge clk_p); #1;
    cpuslow = 0;
    repeat (10) @(posedge clk_p);

    repeat (40) begin
      case ($urandom_range(0, 6))
        0, 1: bus_tx(0);
        2:    bus_tx(1);
        3:    bus_tx(2);
        4:    vec_tx(1);
        5:    vec_tx(0);
        default: rom_abort();
      endcase
    end

    tick(1); tick(1); tick(1);
    tick(0); tick(0);
    tick(1); tick(1);
    b = 0;
    repeat (20) begin
      if ($urandom_range(0, 3) == 0) b = !b;
      tick(b);
    end
    tick(0); tick(0);
    if (model_status) begin
      tick(1); tick(1);
    end

`ifdef BUS_TIMEOUT_EN
    tmo_tx(0);
    tmo_tx(5);
    tmo_race();
`endif

    @(posedge clk_p); #1;
    cpuslow = 1;
    cpu_adr = {4'b1110, 13'($urandom)};
    rom_dat_i = 16'($urandom);
    cpu_cyc = 1;
    cpu_stb = 1;
    bq.push_back('{rom_dat_i, ROM_WAIT + 1, 1'b0});
    repeat (ROM_WAIT + 2) @(posedge clk_p);
    #1 dclo = 1;
    model_reset();
    @(posedge clk_p);
    @(negedge clk_p);
    chk("dclo_cpu_ack", cpu_ack, 0);
    chk("dclo_timer_status", timer_status, 1);
    chk("dclo_clk_ena", clk_ena, 1);
    @(posedge clk_p); #1;
    dclo = 0;
    cpu_stb = 0;
    cpu_cyc = 0;
    repeat (2) @(posedge clk_p);
    bus_tx(0);
    bus_tx(2);
    repeat (3) @(posedge clk_p);

    chk("queues_empty", bq.size() + vq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
